// File: rtl/instr_fetch.sv
// Instruction fetch stage in front of the InCache block RAM.
// Issues one word read per cycle. The RAM has one cycle of read latency.
// Fetched instructions go to decode through a valid/ready output register.
// A one-entry skid register catches a read that lands while decode is stalled.
module instr_fetch #(
  parameter int          ADDR_W   = 13,
  parameter int          DATA_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] addra,
  output logic              wea,
  output logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] douta,
  output logic [DATA_W-1:0] instr,
  output logic [31:0]       instr_pc,
  output logic              instr_valid
);

  // Number of byte-address bits that the InCache covers.
  // The PC wraps inside this window.
  localparam int PW = ADDR_W + 2;

  logic [31:0]       r_pc;
  logic              r_inflight;
  logic [31:0]       r_inflight_pc;
  logic [DATA_W-1:0] r_instr;
  logic [31:0]       r_instr_pc;
  logic              r_instr_valid;
  logic [DATA_W-1:0] r_skid_instr;
  logic [31:0]       r_skid_pc;
  logic              r_skid_valid;

  logic              w_issue;
  logic              w_consume;
  logic [31:0]       w_pc_inc;

  // Do not issue when a read would have nowhere to land.
  // That is the case when the skid is full, or when the output is stalled
  // with a read already in flight (that read will take the skid).
  assign w_issue   = fetch_en & ~redirect & ~r_skid_valid &
                     ~(r_instr_valid & ~id_ready & r_inflight);
  assign w_consume = r_instr_valid & id_ready;

  // Increment only the cache-addressable bits, so the PC wraps inside the window.
  // The upper bits keep whatever region the last reset or redirect chose.
  assign w_pc_inc  = {r_pc[31:PW], r_pc[PW-1:0] + PW'(4)};

  assign addra       = r_pc[PW-1:2];
  assign wea         = 1'b0;
  assign dina        = '0;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;

  // PC and in-flight tracking. A redirect flushes the read issued last cycle.
  always_ff @(posedge clka) begin
    if (rst) begin
      r_pc          <= RESET_PC & ~32'h3;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect) begin
      r_pc          <= redirect_pc & ~32'h3;
      r_inflight    <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
        r_pc          <= w_pc_inc;
      end
    end
  end

  // Output register and skid.
  // The skid drains first so that delivery stays in PC order.
  always_ff @(posedge clka) begin
    if (rst) begin
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_skid_instr  <= '0;
      r_skid_pc     <= '0;
      r_skid_valid  <= 1'b0;
    end else if (redirect) begin
      r_instr_valid <= 1'b0;
      r_skid_valid  <= 1'b0;
    end else if (!r_instr_valid || w_consume) begin
      if (r_skid_valid) begin
        r_instr       <= r_skid_instr;
        r_instr_pc    <= r_skid_pc;
        r_instr_valid <= 1'b1;
        r_skid_valid  <= r_inflight;
        if (r_inflight) begin
          r_skid_instr <= douta;
          r_skid_pc    <= r_inflight_pc;
        end
      end else if (r_inflight) begin
        r_instr       <= douta;
        r_instr_pc    <= r_inflight_pc;
        r_instr_valid <= 1'b1;
      end else begin
        r_instr_valid <= 1'b0;
      end
    end else if (r_inflight) begin
      r_skid_instr <= douta;
      r_skid_pc    <= r_inflight_pc;
      r_skid_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch.
// Stimulus pushes the expected PC stream into a queue. Monitors pop from the
// queue and compare on every accepted transfer.
module tb_instr_fetch;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;

  logic              clka = 1'b0;
  // dut0 (RESET_PC = 0)
  logic              rst, fetch_en, redirect, id_ready;
  logic [31:0]       redirect_pc;
  logic [ADDR_W-1:0] addra0;
  logic              wea0;
  logic [DATA_W-1:0] dina0, douta0, instr0;
  logic [31:0]       instr_pc0;
  logic              instr_valid0;
  // dut1 (RESET_PC = 0x7FF8), free-running wrap test
  logic              rst1, fen1;
  logic [ADDR_W-1:0] addra1;
  logic              wea1;
  logic [DATA_W-1:0] dina1, douta1, instr1;
  logic [31:0]       instr_pc1;
  logic              instr_valid1;

  int errors = 0;
  int checks = 0;
  int n0 = 0;
  int n1 = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  always #5 clka = ~clka;

  instr_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(32'h0)) dut0 (
    .clka(clka), .rst(rst), .fetch_en(fetch_en), .redirect(redirect),
    .redirect_pc(redirect_pc), .id_ready(id_ready), .addra(addra0), .wea(wea0),
    .dina(dina0), .douta(douta0), .instr(instr0), .instr_pc(instr_pc0),
    .instr_valid(instr_valid0));

  instr_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(32'h7FF8)) dut1 (
    .clka(clka), .rst(rst1), .fetch_en(fen1), .redirect(1'b0),
    .redirect_pc(32'h0), .id_ready(1'b1), .addra(addra1), .wea(wea1),
    .dina(dina1), .douta(douta1), .instr(instr1), .instr_pc(instr_pc1),
    .instr_valid(instr_valid1));

  // InCache models: mem[k] = 0x1000 + k, one-cycle read latency.
  always @(posedge clka) begin
    douta0 <= 32'h1000 + 32'(addra0);
    douta1 <= 32'h1000 + 32'(addra1);
  end

  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    return 32'h1000 + ((pc >> 2) & 32'h1FFF);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  // Refill q0 with a contiguous PC stream that starts at pc.
  task automatic restart_q0(input logic [31:0] pc);
    q0.delete();
    for (int k = 0; k < 400; k++) q0.push_back((pc + 32'(4 * k)) & 32'h7FFC);
  endtask

  // dut0 monitor. Transfers are sampled at the negedge before the edge that commits them.
  always @(negedge clka) begin
    if (!rst) begin
      if (wea0 !== 1'b0 || dina0 !== '0) begin
        errors++;
        $display("FAIL ram_write: wea=%b dina=%h required 0/0", wea0, dina0);
      end
      checks++;
      if (32'(dut0.r_instr_valid) + 32'(dut0.r_skid_valid) + 32'(dut0.r_inflight) > 2) begin
        errors++;
        $display("FAIL occupancy: out=%b skid=%b infl=%b exceeds 2",
                 dut0.r_instr_valid, dut0.r_skid_valid, dut0.r_inflight);
      end
      if (instr_valid0 && id_ready && !redirect) begin
        n0++;
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb0_empty: unexpected pc %h", instr_pc0);
        end else begin
          automatic logic [31:0] e = q0.pop_front();
          chk("sb0_pc", instr_pc0, e);
          chk("sb0_instr", instr0, exp_instr(e));
        end
      end
    end
  end

  // dut1 monitor (always ready).
  always @(negedge clka) begin
    if (!rst1 && instr_valid1) begin
      n1++;
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb1_empty: unexpected pc %h", instr_pc1);
      end else begin
        automatic logic [31:0] e = q1.pop_front();
        chk("sb1_pc", instr_pc1, e);
        chk("sb1_instr", instr1, exp_instr(e));
      end
    end
  end

  initial begin
    rst = 1; rst1 = 1; fetch_en = 0; fen1 = 0; redirect = 0; redirect_pc = 0; id_ready = 1;
    for (int k = 0; k < 40; k++) q1.push_back((32'h7FF8 + 32'(4 * k)) & 32'h7FFC);
    tick(); tick();
    chk("rst_valid", 32'(instr_valid0), 0);
    chk("rst_addra", 32'(addra0), 0);
    chk("rst_addra1", 32'(addra1), 32'h1FFE);
    chk("rst_instr", instr0, 0);

    // Test 1: free run from reset.
    restart_q0(0);
    rst = 0; fetch_en = 1; rst1 = 0; fen1 = 1;
    tick();
    chk("lat_valid_t1", 32'(instr_valid0), 0);
    chk("addra_t1", 32'(addra0), 1);
    chk("wrap_addra_t1", 32'(addra1), 32'h1FFF);
    tick();
    chk("lat_valid_t2", 32'(instr_valid0), 1);
    chk("lat_instr_t2", instr0, 32'h1000);
    chk("lat_pc_t2", instr_pc0, 0);
    chk("wrap_addra_t2", 32'(addra1), 0);
    for (int k = 0; k < 8; k++) tick();

    // Test 2: decode stall for 5 cycles. The presented instr must hold.
    id_ready = 0;
    for (int k = 0; k < 5; k++) tick();
    chk("stall_hold", instr_pc0, q0[0]);
    chk("stall_valid", 32'(instr_valid0), 1);
    id_ready = 1;
    for (int k = 0; k < 10; k++) tick();
    fen1 = 0;

    // Test 3: redirect while stalled with the skid full.
    id_ready = 0;
    tick(); tick(); tick();
    redirect = 1; redirect_pc = 32'h0102; restart_q0(32'h100);
    tick();
    chk("redir_valid", 32'(instr_valid0), 0);
    chk("redir_addra", 32'(addra0), 32'h40);
    redirect = 0; id_ready = 1;
    tick();
    chk("redir_valid_t1", 32'(instr_valid0), 0);
    tick();
    chk("redir_valid_t2", 32'(instr_valid0), 1);
    chk("redir_pc_t2", instr_pc0, 32'h100);
    for (int k = 0; k < 6; k++) tick();

    // Back-to-back redirects: the last one wins.
    redirect = 1; redirect_pc = 32'h200; q0.delete();
    tick();
    redirect_pc = 32'h300; restart_q0(32'h300);
    tick();
    redirect = 0;
    tick(); tick();
    chk("b2b_pc", instr_pc0, 32'h300);
    for (int k = 0; k < 4; k++) tick();

    // Redirect with fetch disabled: flush, then nothing issues until enabled.
    fetch_en = 0; redirect = 1; redirect_pc = 32'h406; restart_q0(32'h404);
    tick();
    redirect = 0;
    tick(); tick(); tick();
    chk("fen0_valid", 32'(instr_valid0), 0);
    chk("fen0_addra", 32'(addra0), 32'h101);
    fetch_en = 1;
    tick(); tick();
    chk("fen1_pc", instr_pc0, 32'h404);

    // Test 5: fetch_en toggles every cycle, random decode backpressure.
    for (int k = 0; k < 200; k++) begin
      fetch_en = ~fetch_en;
      id_ready = 1'($urandom_range(0, 1));
      tick();
    end
    fetch_en = 1; id_ready = 1;
    for (int k = 0; k < 5; k++) tick();

    // Test 6: reset with both the output and the skid full.
    id_ready = 0;
    tick(); tick(); tick();
    rst = 1; restart_q0(0);
    tick();
    chk("rst2_valid", 32'(instr_valid0), 0);
    chk("rst2_addra", 32'(addra0), 0);
    rst = 0; id_ready = 1;
    for (int k = 0; k < 10; k++) tick();

    checks++;
    if (n0 < 60) begin errors++; $display("FAIL xfer0_count: got %0d required >= 60", n0); end
    checks++;
    if (n1 < 15 || q1.size() + n1 != 40) begin
      errors++;
      $display("FAIL xfer1_count: got %0d delivered, %0d left of 40", n1, q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
